sd_read_sequencer: RTL and testbench

// Hardware sequencer for multi-sector SD reads: arms the DAT receiver, issues CMD17/CMD18, checks the R1 response,

---
 rtl/sd_pkg.sv | 51 +++++
 rtl/sd_read_sequencer_if.sv | 43 ++++
 rtl/sd_seq_timer.sv | 34 +++
 rtl/sd_read_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_sd_read_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared command indices, R1 mask, error codes and sequencer
//                state encoding for the SD read sequencer.
//  Revision    : 1.0
// ============================================================================
package sd_pkg;

  localparam logic [5:0]  SD_CMD17      = 6'd17;
  localparam logic [5:0]  SD_CMD18      = 6'd18;
  localparam logic [5:0]  SD_CMD12      = 6'd12;
  localparam logic [31:0] R1_ERROR_MASK = 32'hFFF8_0000;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_CMD_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_CMD_CRC     = 3'd2;
  localparam logic [2:0] ERR_R1_STATUS   = 3'd3;
  localparam logic [2:0] ERR_DAT_CRC     = 3'd4;
  localparam logic [2:0] ERR_DAT_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_ABORTED     = 3'd6;
  localparam logic [2:0] ERR_STOP_FAIL   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DAT_ARM    = 3'd1,
    ST_CMD_ISSUE  = 3'd2,
    ST_CMD_WAIT   = 3'd3,
    ST_DAT_WAIT   = 3'd4,
    ST_STOP_ISSUE = 3'd5,
    ST_STOP_WAIT  = 3'd6,
    ST_FINISH     = 3'd7
  } seq_state_t;

  // Completion check for any command: timeout beats CRC beats R1 status bits.
  function automatic logic [2:0] cmd_check(input logic        timeout,
                                           input logic        crc_error,
                                           input logic [31:0] r1);
    logic [2:0] code;
    code = ERR_NONE;
    if (timeout)
      code = ERR_CMD_TIMEOUT;
    else if (crc_error)
      code = ERR_CMD_CRC;
    else if ((r1 & R1_ERROR_MASK) != 32'd0)
      code = ERR_R1_STATUS;
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_read_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_read_sequencer_if
//  Description : Command-engine and DAT-engine connections of the sequencer.
//  Revision    : 1.0
// ============================================================================
interface sd_read_sequencer_if;
  logic [5:0]  o_command_index;
  logic [31:0] o_command_argument;
  logic        o_command_long_response;
  logic        o_command_skip_response;
  logic        o_command_start;
  logic        i_command_busy;
  logic        i_command_timeout;
  logic        i_command_response_crc_error;
  logic [31:0] i_command_response;
  logic        o_dat_direction;
  logic [6:0]  o_dat_block_size;
  logic [10:0] o_dat_num_blocks;
  logic        o_dat_start;
  logic        o_dat_stop;
  logic        i_dat_busy;
  logic        i_dat_crc_error;

  modport master (
    output o_command_index, o_command_argument, o_command_long_response,
           o_command_skip_response, o_command_start,
           o_dat_direction, o_dat_block_size, o_dat_num_blocks,
           o_dat_start, o_dat_stop,
    input  i_command_busy, i_command_timeout, i_command_response_crc_error,
           i_command_response, i_dat_busy, i_dat_crc_error
  );

  modport slave (
    input  o_command_index, o_command_argument, o_command_long_response,
           o_command_skip_response, o_command_start,
           o_dat_direction, o_dat_block_size, o_dat_num_blocks,
           o_dat_start, o_dat_stop,
    output i_command_busy, i_command_timeout, i_command_response_crc_error,
           i_command_response, i_dat_busy, i_dat_crc_error
  );
endinterface
`default_nettype wire

// File: rtl/sd_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_seq_timer
//  Description : Loadable down-counter that saturates at zero; o_expired is
//                high while the count is zero.
//  Revision    : 1.0
// ============================================================================
module sd_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_expired
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_count <= '0;
    else if (i_load)
      r_count <= i_load_value;
    else if (r_count != '0)
      r_count <= r_count - c_one;
  end

  assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sd_read_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_read_sequencer
//  Description : Runs one CMD17/CMD18 read end to end (DAT arm, command, R1
//                check, DAT watchdog, CMD12) and reports a single done/error.
//  Revision    : 1.0
// ============================================================================
module sd_read_sequencer
  import sd_pkg::*;
#(
  parameter logic [23:0] DATA_TIMEOUT = 24'd10_000_000,
  parameter int unsigned BUSY_GUARD   = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [31:0]         i_sector,
  input  logic [10:0]         i_count,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [2:0]          o_error_code,
  sd_read_sequencer_if.master bus
);

  seq_state_t  r_state, w_state_next, w_after_data;
  logic        r_multi, r_abort_seen, r_error, r_dat_stop;
  logic [2:0]  r_error_code;
  logic [5:0]  r_cmd_index;
  logic [31:0] r_cmd_argument;
  logic [10:0] r_dat_num_blocks;

  logic        w_accept, w_err_set, w_dat_stop_set, w_stop_cmd;
  logic        w_guard_load, w_wdog_load, w_guard_expired, w_wdog_expired;
  logic [2:0]  w_err_code, w_cmd_code;

  sd_seq_timer #(.WIDTH(8)) u_guard (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_guard_load),
    .i_load_value (8'(BUSY_GUARD)),
    .o_expired    (w_guard_expired)
  );

  sd_seq_timer #(.WIDTH(24)) u_watchdog (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_wdog_load),
    .i_load_value (DATA_TIMEOUT),
    .o_expired    (w_wdog_expired)
  );

  assign w_cmd_code   = cmd_check(bus.i_command_timeout, bus.i_command_response_crc_error,
                                  bus.i_command_response);
  assign w_after_data = r_multi ? ST_STOP_ISSUE : ST_FINISH;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_err_set      = 1'b0;
    w_err_code     = ERR_NONE;
    w_dat_stop_set = 1'b0;
    w_guard_load   = 1'b0;
    w_wdog_load    = 1'b0;
    w_stop_cmd     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_accept     = 1'b1;
          w_state_next = (i_count == 11'd0) ? ST_FINISH : ST_DAT_ARM;
        end
      end
      ST_DAT_ARM, ST_CMD_ISSUE: begin
        w_guard_load = 1'b1;
        if (i_abort) begin
          w_err_set      = 1'b1;
          w_err_code     = ERR_ABORTED;
          w_dat_stop_set = 1'b1;
          w_state_next   = ST_FINISH;
        end else begin
          w_state_next = (r_state == ST_DAT_ARM) ? ST_CMD_ISSUE : ST_CMD_WAIT;
        end
      end
      ST_CMD_WAIT: begin
        if (i_abort && !r_abort_seen) begin
          w_err_set      = 1'b1;
          w_err_code     = ERR_ABORTED;
          w_dat_stop_set = 1'b1;
        end
        // An abort lets the command finish, then skips the data phase entirely.
        if (w_guard_expired && !bus.i_command_busy) begin
          if (r_abort_seen || i_abort) begin
            w_state_next = w_after_data;
            w_stop_cmd   = r_multi;
          end else if (w_cmd_code != ERR_NONE) begin
            w_err_set      = 1'b1;
            w_err_code     = w_cmd_code;
            w_dat_stop_set = 1'b1;
            w_state_next   = ST_FINISH;
          end else begin
            w_guard_load = 1'b1;
            w_wdog_load  = 1'b1;
            w_state_next = ST_DAT_WAIT;
          end
        end
      end
      ST_DAT_WAIT: begin
        if (w_guard_expired && !bus.i_dat_busy) begin
          if (bus.i_dat_crc_error) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_DAT_CRC;
          end else if (i_abort) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_ABORTED;
          end
          w_state_next = w_after_data;
          w_stop_cmd   = r_multi;
        end else if (i_abort || w_wdog_expired) begin
          w_err_set      = 1'b1;
          w_err_code     = i_abort ? ERR_ABORTED : ERR_DAT_TIMEOUT;
          w_dat_stop_set = 1'b1;
          w_state_next   = w_after_data;
          w_stop_cmd     = r_multi;
        end
      end
      ST_STOP_ISSUE: begin
        w_guard_load = 1'b1;
        if (i_abort) begin
          w_err_set  = 1'b1;
          w_err_code = ERR_ABORTED;
        end
        w_state_next = ST_STOP_WAIT;
      end
      ST_STOP_WAIT: begin
        if (i_abort) begin
          w_err_set  = 1'b1;
          w_err_code = ERR_ABORTED;
        end
        if (w_guard_expired && !bus.i_command_busy) begin
          if (!w_err_set && w_cmd_code != ERR_NONE) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_STOP_FAIL;
          end
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Only the first recorded error survives until the next accepted start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_multi          <= 1'b0;
      r_abort_seen     <= 1'b0;
      r_error          <= 1'b0;
      r_error_code     <= ERR_NONE;
      r_cmd_index      <= '0;
      r_cmd_argument   <= '0;
      r_dat_num_blocks <= '0;
      r_dat_stop       <= 1'b0;
    end else begin
      r_dat_stop <= w_dat_stop_set;
      if (w_accept) begin
        r_error      <= 1'b0;
        r_error_code <= ERR_NONE;
        r_abort_seen <= 1'b0;
        r_multi      <= (i_count != 11'd1);
        if (i_count != 11'd0) begin
          r_cmd_index      <= (i_count == 11'd1) ? SD_CMD17 : SD_CMD18;
          r_cmd_argument   <= i_sector;
          r_dat_num_blocks <= i_count - 11'd1;
        end else begin
          r_dat_num_blocks <= '0;
        end
      end else begin
        if (w_err_set && !r_error) begin
          r_error      <= 1'b1;
          r_error_code <= w_err_code;
        end
        if (r_state == ST_CMD_WAIT && i_abort)
          r_abort_seen <= 1'b1;
        if (w_stop_cmd) begin
          r_cmd_index    <= SD_CMD12;
          r_cmd_argument <= '0;
        end
      end
    end
  end

  assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign o_done       = (r_state == ST_FINISH);
  assign o_error      = r_error;
  assign o_error_code = r_error_code;

  assign bus.o_command_index         = r_cmd_index;
  assign bus.o_command_argument      = r_cmd_argument;
  assign bus.o_command_long_response = 1'b0;
  assign bus.o_command_skip_response = 1'b0;
  assign bus.o_command_start         = (r_state == ST_CMD_ISSUE) || (r_state == ST_STOP_ISSUE);
  assign bus.o_dat_direction         = 1'b0;
  assign bus.o_dat_block_size        = 7'd127;
  assign bus.o_dat_num_blocks        = r_dat_num_blocks;
  assign bus.o_dat_start             = (r_state == ST_DAT_ARM);
  assign bus.o_dat_stop              = r_dat_stop;

endmodule
`default_nettype wire

// File: tb/tb_sd_read_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_read_sequencer
//  Description : Directed bench with simple command/DAT engine models.
//  Revision    : 1.0
// ============================================================================
module tb_sd_read_sequencer;

  localparam logic [23:0] TB_TIMEOUT = 24'd60;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_abort;
  logic [31:0] i_sector;
  logic [10:0] i_count;
  logic        o_busy, o_done, o_error;
  logic [2:0]  o_error_code;

  sd_read_sequencer_if u_bus ();

  sd_read_sequencer #(.DATA_TIMEOUT(TB_TIMEOUT), .BUSY_GUARD(2)) u_dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_sector     (i_sector),
    .i_count      (i_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_error_code (o_error_code),
    .bus          (u_bus)
  );

  always #5 i_clk = ~i_clk;

  // Engine configuration, written only by the stimulus process.
  logic        cfg_cmd_to = 1'b0, cfg_cmd_crc = 1'b0, cfg_dat_crc = 1'b0, cfg_dat_stuck = 1'b0;
  logic [31:0] cfg_r1 = 32'd0;
  int          cfg_dat_len = 20;

  logic        cmd_busy = 1'b0, dat_busy = 1'b0;
  logic [5:0]  cmd_last_idx = 6'd0;
  int          cmd_cnt = 0, dat_cnt = 0;

  assign u_bus.i_command_busy               = cmd_busy;
  assign u_bus.i_command_timeout            = !cmd_busy && cmd_last_idx != 6'd12 && cfg_cmd_to;
  assign u_bus.i_command_response_crc_error = !cmd_busy && cmd_last_idx != 6'd12 && cfg_cmd_crc;
  assign u_bus.i_command_response           = (cmd_last_idx == 6'd12) ? 32'd0 : cfg_r1;
  assign u_bus.i_dat_busy                   = dat_busy;
  assign u_bus.i_dat_crc_error              = !dat_busy && cfg_dat_crc;

  always @(posedge i_clk) begin
    if (i_reset) begin
      cmd_busy <= 1'b0; dat_busy <= 1'b0; cmd_cnt <= 0; dat_cnt <= 0; cmd_last_idx <= 6'd0;
    end else begin
      if (u_bus.o_command_start) begin
        cmd_busy <= 1'b1; cmd_cnt <= 5; cmd_last_idx <= u_bus.o_command_index;
      end else if (cmd_busy) begin
        if (cmd_cnt == 1) cmd_busy <= 1'b0;
        else cmd_cnt <= cmd_cnt - 1;
      end
      if (u_bus.o_dat_start) begin
        dat_busy <= 1'b1; dat_cnt <= cfg_dat_len;
      end else if (u_bus.o_dat_stop) begin
        dat_busy <= 1'b0;
      end else if (dat_busy && !cfg_dat_stuck) begin
        if (dat_cnt == 1) dat_busy <= 1'b0;
        else dat_cnt <= dat_cnt - 1;
      end
    end
  end

  // Event monitor: counters only ever increase; checks work on deltas.
  int          ncyc = 0, n_dat_start = 0, n_dat_stop = 0, n_cmd = 0, n_cmd12 = 0, n_done = 0;
  int          n_cmd_fall = 0, cmd_fall_cyc = 0, dat_stop_cyc = 0, n_cmd12_dat_busy = 0;
  logic        prev_cmd_busy = 1'b0, cap_busy_done = 1'b0, cap_err = 1'b0;
  logic [5:0]  cap_idx = 6'd0;
  logic [31:0] cap_arg = 32'd0, cap_stop_arg = 32'hFFFF_FFFF;
  logic [10:0] cap_nblk = 11'd0;
  logic [2:0]  cap_code = 3'd0;

  always @(negedge i_clk) begin
    ncyc          <= ncyc + 1;
    prev_cmd_busy <= cmd_busy;
    if (prev_cmd_busy && !cmd_busy) begin
      n_cmd_fall <= n_cmd_fall + 1; cmd_fall_cyc <= ncyc;
    end
    if (u_bus.o_dat_start) begin
      n_dat_start <= n_dat_start + 1; cap_nblk <= u_bus.o_dat_num_blocks;
    end
    if (u_bus.o_dat_stop) begin
      n_dat_stop <= n_dat_stop + 1; dat_stop_cyc <= ncyc;
    end
    if (u_bus.o_command_start) begin
      if (u_bus.o_command_index == 6'd12) begin
        n_cmd12 <= n_cmd12 + 1; cap_stop_arg <= u_bus.o_command_argument;
        if (dat_busy) n_cmd12_dat_busy <= n_cmd12_dat_busy + 1;
      end else begin
        n_cmd <= n_cmd + 1; cap_idx <= u_bus.o_command_index; cap_arg <= u_bus.o_command_argument;
      end
    end
    if (o_done) begin
      n_done <= n_done + 1; cap_code <= o_error_code; cap_err <= o_error; cap_busy_done <= o_busy;
    end
  end

  int checks = 0, errors = 0;
  int b_ds, b_dp, b_c, b_c12, b_d, b_fall, b_c12db, t_fall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  task automatic snap();
    b_ds = n_dat_start; b_dp = n_dat_stop; b_c = n_cmd; b_c12 = n_cmd12;
    b_d = n_done; b_fall = n_cmd_fall; b_c12db = n_cmd12_dat_busy;
  endtask

  task automatic launch(input logic [31:0] sec, input logic [10:0] cnt, input logic exp_busy);
    tick(1);
    snap();
    i_sector = sec; i_count = cnt; i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'(exp_busy));
    chk("error_cleared", 32'(o_error), 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_done == b_d && k < 400) begin tick(1); k++; end
    chk("done_seen", n_done - b_d, 1);
  endtask

  task automatic wait_cmd_fall();
    int k = 0;
    while (n_cmd_fall == b_fall && k < 100) begin tick(1); k++; end
    chk("cmd_fall_seen", n_cmd_fall - b_fall, 1);
    t_fall = cmd_fall_cyc;
  endtask

  task automatic expect_end(input string tag, input int dstop, input int c12, input logic [2:0] code);
    chk({tag, "_dat_stop"}, n_dat_stop - b_dp, dstop);
    chk({tag, "_cmd12"}, n_cmd12 - b_c12, c12);
    chk({tag, "_code"}, 32'(cap_code), 32'(code));
    chk({tag, "_error"}, 32'(cap_err), (code != 3'd0) ? 1 : 0);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_sector = 32'd0; i_count = 11'd0;
    tick(3);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_code", 32'(o_error_code), 0);
    chk("rst_cmd_start", 32'(u_bus.o_command_start), 0);
    chk("rst_dat_start", 32'(u_bus.o_dat_start), 0);
    chk("rst_index", 32'(u_bus.o_command_index), 0);
    chk("rst_nblk", 32'(u_bus.o_dat_num_blocks), 0);
    i_reset = 1'b0;

    // Single block read
    launch(32'h1234, 11'd1, 1'b1);
    wait_done();
    chk("c1_index", 32'(cap_idx), 17);
    chk("c1_arg", cap_arg, 32'h1234);
    chk("c1_nblk", 32'(cap_nblk), 0);
    chk("c1_dat_start", n_dat_start - b_ds, 1);
    chk("c1_busy_at_done", 32'(cap_busy_done), 0);
    expect_end("c1", 0, 0, 3'd0);

    // Multi-block read closed by CMD12 after DAT finishes
    launch(32'hABCD_0000, 11'd8, 1'b1);
    wait_done();
    chk("c8_index", 32'(cap_idx), 18);
    chk("c8_arg", cap_arg, 32'hABCD_0000);
    chk("c8_nblk", 32'(cap_nblk), 7);
    chk("c8_stop_arg", cap_stop_arg, 0);
    chk("c8_cmd12_after_dat", n_cmd12_dat_busy - b_c12db, 0);
    chk("c8_block_size", 32'(u_bus.o_dat_block_size), 127);
    expect_end("c8", 0, 1, 3'd0);

    // Command timeout on CMD18
    cfg_cmd_to = 1'b1;
    launch(32'h10, 11'd8, 1'b1);
    wait_done();
    cfg_cmd_to = 1'b0;
    expect_end("cto", 1, 0, 3'd1);

    // R1 error bit, then benign R1 bits
    cfg_r1 = 32'h0400_0900;
    launch(32'h20, 11'd4, 1'b1);
    wait_done();
    expect_end("r1bad", 1, 0, 3'd3);
    cfg_r1 = 32'h0000_0900;
    launch(32'h20, 11'd4, 1'b1);
    wait_done();
    expect_end("r1ok", 0, 1, 3'd0);
    cfg_r1 = 32'd0;

    // DAT CRC error still closes with CMD12
    cfg_dat_crc = 1'b1;
    launch(32'h30, 11'd4, 1'b1);
    wait_done();
    cfg_dat_crc = 1'b0;
    expect_end("dcrc", 0, 1, 3'd4);

    // DAT watchdog: entry one cycle after busy is seen low, pulse registered
    cfg_dat_stuck = 1'b1;
    launch(32'h40, 11'd4, 1'b1);
    wait_cmd_fall();
    wait_done();
    expect_end("dto", 1, 1, 3'd5);
    chk("dto_window", ((dat_stop_cyc - t_fall) >= int'(TB_TIMEOUT) + 1 &&
                       (dat_stop_cyc - t_fall) <= int'(TB_TIMEOUT) + 3) ? 1 : 0, 1);

    // Abort during DAT_WAIT on CMD18
    launch(32'h50, 11'd4, 1'b1);
    wait_cmd_fall();
    tick(5);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    wait_done();
    expect_end("abrt", 1, 1, 3'd6);

    // count == 0 completes without touching the engines
    cfg_dat_stuck = 1'b0;
    launch(32'h60, 11'd0, 1'b0);
    chk("c0_done_next", 32'(o_done), 1);
    tick(3);
    chk("c0_cmds", n_cmd - b_c, 0);
    chk("c0_dat", n_dat_start - b_ds, 0);
    chk("c0_code", 32'(cap_code), 0);

    // Abort in IDLE swallows a simultaneous start
    tick(1);
    snap();
    i_count = 11'd1; i_start = 1'b1; i_abort = 1'b1;
    tick(1);
    i_start = 1'b0; i_abort = 1'b0;
    chk("idle_abort_busy", 32'(o_busy), 0);
    tick(10);
    chk("idle_abort_cmds", n_cmd - b_c, 0);
    chk("idle_abort_done", n_done - b_d, 0);

    // Reset in the middle of DAT_WAIT
    cfg_dat_stuck = 1'b1;
    launch(32'h70, 11'd4, 1'b1);
    wait_cmd_fall();
    tick(5);
    i_reset = 1'b1;
    tick(1);
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_error", 32'(o_error), 0);
    chk("mrst_index", 32'(u_bus.o_command_index), 0);
    chk("mrst_arg", u_bus.o_command_argument, 0);
    chk("mrst_nblk", 32'(u_bus.o_dat_num_blocks), 0);
    i_reset = 1'b0;
    cfg_dat_stuck = 1'b0;
    tick(100);
    chk("mrst_no_done", n_done - b_d, 0);
    chk("mrst_no_cmd12", n_cmd12 - b_c12, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
